// File: rtl/pixel_line_buffer.sv
// pixel_line_buffer: multi-line video buffer presenting vertically aligned pixel taps
module pixel_line_buffer #(
    parameter int DATA_W   = 24,
    parameter int MAX_LINE = 2048,
    parameter int LINES    = 3,
    parameter int ADDR_W   = 11
) (
    input  logic                      PixelClk,
    input  logic                      aPixelClkLckd,
    input  logic                      pVS,
    input  logic                      pVDE,
    input  logic [DATA_W-1:0]         pData,
    output logic                      oVDE,
    output logic [LINES*DATA_W-1:0]   oTaps,
    output logic [ADDR_W:0]           oLineLen,
    output logic                      oOverflow
);
    localparam int SW = LINES > 2 ? $clog2(LINES - 1) : 1;
    localparam int FW = $clog2(LINES);
    localparam logic [ADDR_W:0] MAX_COL  = (ADDR_W + 1)'(MAX_LINE);
    localparam logic [FW-1:0]   FULL     = FW'(LINES - 1);
    localparam logic [SW-1:0]   LAST_SEL = SW'(LINES - 2);

    logic [DATA_W-1:0] mem [LINES-1][2**ADDR_W];
    logic [DATA_W-1:0] ramQ [LINES-1];
    logic [DATA_W-1:0] tap0Q;
    logic [ADDR_W:0]   colQ, effCol, colInc;
    logic [ADDR_W-1:0] addr;
    logic [SW-1:0]     wselQ, effWsel, rselQ;
    logic [FW-1:0]     filledQ;
    logic              pVdeQ, lineEnd, wrEn;

    // frame start wins over current position, so a pixel coincident with pVS lands at column 0 of ring slot 0
    always_comb begin
        effCol  = pVS ? '0 : colQ;
        effWsel = pVS ? '0 : wselQ;
        addr    = effCol[ADDR_W-1:0];
        colInc  = (effCol == MAX_COL) ? MAX_COL : effCol + 1'b1;
        lineEnd = pVdeQ & ~pVDE & ~pVS;
        wrEn    = pVDE & (effCol < MAX_COL);
    end

    // line memory write port; contents survive reset
    always_ff @(posedge PixelClk) begin
        if (wrEn) mem[effWsel][addr] <= pData;
    end

    // registered read of every ring slot, read-before-write, held while video is inactive
    always_ff @(posedge PixelClk or negedge aPixelClkLckd) begin
        if (!aPixelClkLckd) begin
            for (int g = 0; g < LINES - 1; g++) ramQ[g] <= '0;
        end else if (pVDE) begin
            for (int g = 0; g < LINES - 1; g++) ramQ[g] <= mem[g][addr];
        end
    end

    // column, ring pointer, fill level, line length and overflow tracking
    always_ff @(posedge PixelClk or negedge aPixelClkLckd) begin
        if (!aPixelClkLckd) begin
            colQ      <= '0;
            wselQ     <= '0;
            rselQ     <= '0;
            filledQ   <= '0;
            pVdeQ     <= 1'b0;
            tap0Q     <= '0;
            oLineLen  <= '0;
            oOverflow <= 1'b0;
        end else begin
            pVdeQ     <= pVDE;
            oOverflow <= ~pVS & (oOverflow | (pVDE & (effCol == MAX_COL)));
            colQ      <= pVDE ? colInc : (pVS | lineEnd) ? '0 : colQ;
            if (pVDE) begin
                tap0Q <= pData;
                rselQ <= effWsel;
            end
            if (pVS) begin
                wselQ   <= '0;
                filledQ <= '0;
            end else if (lineEnd) begin
                wselQ    <= (wselQ == LAST_SEL) ? '0 : wselQ + 1'b1;
                filledQ  <= (filledQ == FULL) ? FULL : filledQ + 1'b1;
                oLineLen <= colQ;
            end
        end
    end

    // tap k reads the slot written k lines before the slot being written at read time
    always_comb begin
        oTaps = '0;
        oTaps[DATA_W-1:0] = tap0Q;
        for (int k = 1; k < LINES; k++) begin
            for (int g = 0; g < LINES - 1; g++) begin
                if (rselQ == SW'((g + k) % (LINES - 1))) oTaps[k*DATA_W +: DATA_W] = ramQ[g];
            end
        end
    end

    assign oVDE = pVdeQ & (filledQ == FULL);
endmodule
